// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the fetch PC of the dual-issue front end.
// Arbitrates exception, ERET and the two branch-slot redirects, parks a
// redirect while the pipeline is stalled, and drives the fetch address,
// fetch enable, a one-cycle IF/ID flush pulse and a misaligned-target pulse.
//
// Build option: define PC_REDIR_CNT_EN to build the applied-redirect counter
// behind redirect_cnt; otherwise redirect_cnt is a constant zero.
//
// state | meaning
// ------+------------------------------------------------------------------
// BOOT  | first cycle out of reset, fetch disabled, requests ignored
// RUN   | normal fetch; redirects applied at once unless stalled
// PEND  | stalled with a redirect parked in pend_src/pend_tgt
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380,
    parameter logic [31:0] STEP     = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] cp0_epc,
    input  logic        br1_req,
    input  logic [31:0] br1_tgt,
    input  logic        br2_req,
    input  logic [31:0] br2_tgt,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        addr_err,
    output logic [2:0]  pend_src,
    output logic [31:0] redirect_cnt
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    // Source codes double as priority: a smaller non-zero code wins.
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_EXC  = 3'd1;
    localparam logic [2:0] SRC_ERET = 3'd2;
    localparam logic [2:0] SRC_BR1  = 3'd3;
    localparam logic [2:0] SRC_BR2  = 3'd4;

    logic [1:0]  state;
    logic [31:0] pend_tgt;

    logic [2:0]  req_src;
    logic [31:0] req_tgt;
    logic        req_beats_pend;

    logic [1:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic [2:0]  pend_src_nxt;
    logic [31:0] pend_tgt_nxt;
    logic        load;
    logic [31:0] load_tgt;

    // Pick this cycle's winning request; losers are simply dropped.
    always_comb begin
        req_src = SRC_NONE;
        req_tgt = 32'd0;
        if (exc_req) begin
            req_src = SRC_EXC;
            req_tgt = EXC_VEC;
        end else if (eret_req) begin
            req_src = SRC_ERET;
            req_tgt = cp0_epc;
        end else if (br1_req) begin
            req_src = SRC_BR1;
            req_tgt = br1_tgt;
        end else if (br2_req) begin
            req_src = SRC_BR2;
            req_tgt = br2_tgt;
        end
    end

    // Strictly higher priority than what is parked; ties keep the parked one.
    assign req_beats_pend = (req_src != SRC_NONE) && (req_src < pend_src);

    // Next-state, next-PC and pending-slot decisions.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_src_nxt = pend_src;
        pend_tgt_nxt = pend_tgt;
        load         = 1'b0;
        load_tgt     = 32'd0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (req_src != SRC_NONE) begin
                        load     = 1'b1;
                        load_tgt = req_tgt;
                    end else begin
                        pc_nxt = pc + STEP;
                    end
                end else if (req_src != SRC_NONE) begin
                    pend_src_nxt = req_src;
                    pend_tgt_nxt = req_tgt;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                if (stall) begin
                    if (req_beats_pend) begin
                        pend_src_nxt = req_src;
                        pend_tgt_nxt = req_tgt;
                    end
                end else begin
                    load         = 1'b1;
                    load_tgt     = req_beats_pend ? req_tgt : pend_tgt;
                    pend_src_nxt = SRC_NONE;
                    pend_tgt_nxt = 32'd0;
                    state_nxt    = RUN;
                end
            end
            default: begin
                state_nxt    = BOOT;
                pend_src_nxt = SRC_NONE;
                pend_tgt_nxt = 32'd0;
            end
        endcase
        if (load) begin
            pc_nxt = load_tgt;
        end
    end

    // Register all state and outputs; flush/addr_err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
            addr_err <= 1'b0;
            pend_src <= SRC_NONE;
            pend_tgt <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pc_valid <= (state_nxt == RUN) || (state_nxt == PEND);
            flush    <= load;
            addr_err <= load && (load_tgt[1:0] != 2'b00);
            pend_src <= pend_src_nxt;
            pend_tgt <= pend_tgt_nxt;
        end
    end

`ifdef PC_REDIR_CNT_EN
    logic [31:0] cnt;

    // Count every applied redirect (one per flush pulse); wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 32'd0;
        end else if (load) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign redirect_cnt = cnt;
`else
    assign redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a vector table applied one clock
// per row from a known post-boot state, plus hand-written reset/boot sequences.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] cp0_epc;
    logic        br1_req;
    logic [31:0] br1_tgt;
    logic        br2_req;
    logic [31:0] br2_tgt;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        addr_err;
    logic [2:0]  pend_src;
    logic [31:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    fetch_redirect_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .exc_req(exc_req), .eret_req(eret_req), .cp0_epc(cp0_epc),
        .br1_req(br1_req), .br1_tgt(br1_tgt),
        .br2_req(br2_req), .br2_tgt(br2_tgt),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .addr_err(addr_err),
        .pend_src(pend_src), .redirect_cnt(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        br1;
        logic [31:0] t1;
        logic        br2;
        logic [31:0] t2;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_aerr;
        logic [2:0]  e_pend;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic ex, input logic er, input logic [31:0] epc,
                       input logic b1, input logic [31:0] t1, input logic b2, input logic [31:0] t2,
                       input logic [31:0] e_pc, input logic e_fl, input logic e_ae,
                       input logic [2:0] e_pd, input logic [31:0] e_cnt);
        vec_t v;
        v.stall = s; v.exc = ex; v.eret = er; v.epc = epc;
        v.br1 = b1; v.t1 = t1; v.br2 = b2; v.t2 = t2;
        v.e_pc = e_pc; v.e_flush = e_fl; v.e_aerr = e_ae; v.e_pend = e_pd; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef PC_REDIR_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic drive(input logic s, input logic ex, input logic er, input logic [31:0] epc,
                         input logic b1, input logic [31:0] t1, input logic b2, input logic [31:0] t2);
        stall = s; exc_req = ex; eret_req = er; cp0_epc = epc;
        br1_req = b1; br1_tgt = t1; br2_req = b2; br2_tgt = t2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall, exc, eret, epc, br1, t1, br2, t2 | pc, flush, aerr, pend, cnt
        add(0,0,0,0,           0,0,           0,0,           32'hBFC0_0008,0,0,0,0);
        add(0,0,0,0,           0,0,           0,0,           32'hBFC0_0010,0,0,0,0);
        add(0,0,0,0,           1,32'hBFC0_0100,0,0,          32'hBFC0_0100,1,0,0,1);
        add(0,0,0,0,           0,0,           0,0,           32'hBFC0_0108,0,0,0,1);
        add(1,0,0,0,           0,0,           1,32'h8000_0040,32'hBFC0_0108,0,0,4,1);
        add(1,1,0,0,           0,0,           0,0,           32'hBFC0_0108,0,0,1,1);
        add(1,0,0,0,           1,32'h1234_5678,0,0,          32'hBFC0_0108,0,0,1,1);
        add(0,0,0,0,           0,0,           0,0,           32'hBFC0_0380,1,0,0,2);
        add(0,0,0,0,           0,0,           0,0,           32'hBFC0_0388,0,0,0,2);
        add(0,1,1,32'h8000_1000,0,0,          0,0,           32'hBFC0_0380,1,0,0,3);
        add(0,0,0,0,           1,32'h8000_0002,0,0,          32'h8000_0002,1,1,0,4);
        add(0,0,0,0,           0,0,           0,0,           32'h8000_000A,0,0,0,4);
        add(0,0,1,32'h8000_1000,0,0,          1,32'h0,       32'h8000_1000,1,0,0,5);
        add(1,0,0,0,           1,32'h8000_2000,0,0,          32'h8000_1000,0,0,3,5);
        add(1,0,1,32'h8000_3000,0,0,          0,0,           32'h8000_1000,0,0,2,5);
        add(1,0,0,0,           0,0,           1,32'h0,       32'h8000_1000,0,0,2,5);
        add(1,0,1,32'h8000_4000,0,0,          0,0,           32'h8000_1000,0,0,2,5);
        add(0,0,0,0,           1,32'h8000_5000,0,0,          32'h8000_3000,1,0,0,6);
        add(1,0,0,0,           0,0,           1,32'h8000_6000,32'h8000_3000,0,0,4,6);
        add(0,1,0,0,           0,0,           0,0,           32'hBFC0_0380,1,0,0,7);
        add(1,0,0,0,           0,0,           0,0,           32'hBFC0_0380,0,0,0,7);
        add(0,0,0,0,           0,0,           1,32'hFFFF_FFF0,32'hFFFF_FFF0,1,0,0,8);
        add(0,0,0,0,           0,0,           0,0,           32'hFFFF_FFF8,0,0,0,8);
        add(0,0,0,0,           0,0,           0,0,           32'h0000_0000,0,0,0,8);
        add(0,0,0,0,           0,0,           0,0,           32'h0000_0008,0,0,0,8);

        reset = 1'b1;
        drive(0,0,0,0,0,0,0,0);
        tick();
        tick();
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_valid", {31'd0, pc_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_aerr", {31'd0, addr_err}, 32'd0);
        chk("rst_pend", {29'd0, pend_src}, 32'd0);
        chk("rst_cnt", redirect_cnt, 32'd0);

        reset = 1'b0;
        drive(0,1,0,0,1,32'h1111_1110,0,0);
        #1;
        chk("boot_valid_low", {31'd0, pc_valid}, 32'd0);
        tick();
        chk("boot_pc", pc, 32'hBFC0_0000);
        chk("boot_valid", {31'd0, pc_valid}, 32'd1);
        chk("boot_flush", {31'd0, flush}, 32'd0);
        chk("boot_cnt", redirect_cnt, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].exc, vecs[i].eret, vecs[i].epc,
                  vecs[i].br1, vecs[i].t1, vecs[i].br2, vecs[i].t2);
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
            chk($sformatf("v%0d_aerr", i), {31'd0, addr_err}, {31'd0, vecs[i].e_aerr});
            chk($sformatf("v%0d_pend", i), {29'd0, pend_src}, {29'd0, vecs[i].e_pend});
            chk($sformatf("v%0d_valid", i), {31'd0, pc_valid}, 32'd1);
            chk($sformatf("v%0d_cnt", i), redirect_cnt, cnt_exp(vecs[i].e_cnt));
        end

        // Park a redirect, then reset while still stalled: it must be lost.
        drive(1,0,0,0,1,32'h8000_7000,0,0);
        tick();
        chk("pend_before_rst", {29'd0, pend_src}, 32'd3);
        reset = 1'b1;
        tick();
        chk("pendrst_pc", pc, 32'hBFC0_0000);
        chk("pendrst_pend", {29'd0, pend_src}, 32'd0);
        chk("pendrst_flush", {31'd0, flush}, 32'd0);
        chk("pendrst_valid", {31'd0, pc_valid}, 32'd0);
        chk("pendrst_cnt", redirect_cnt, 32'd0);

        reset = 1'b0;
        drive(0,0,0,0,0,0,0,0);
        tick();
        tick();
        chk("after_rst_pc", pc, 32'hBFC0_0008);
        chk("after_rst_flush", {31'd0, flush}, 32'd0);

        // Redirect then release: flush lasts exactly one cycle.
        drive(0,0,1,32'h8000_0100,0,0,0,0);
        tick();
        chk("eret_pc", pc, 32'h8000_0100);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        drive(0,0,0,0,0,0,0,0);
        tick();
        chk("eret_flush_end", {31'd0, flush}, 32'd0);
        chk("eret_next_pc", pc, 32'h8000_0108);
        chk("eret_cnt", redirect_cnt, cnt_exp(32'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencer for the fetch PC in the dual-issue MIPS front end. It owns the fetch PC register. It arbitrates redirect requests from the exception unit, ERET, and both branch slots, and holds a redirect pending while the pipeline is stalled. It emits the fetch address, fetch enable, and a one-cycle IF/ID flush pulse, sitting between ID/CP0 and the instruction-fetch stage.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, boot fetch address
- EXC_VEC, 32'hBFC0_0380, exception/interrupt entry address
- STEP, 8, sequential PC increment (two instructions per fetch)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hard or soft pipeline stall; hold PC
- exc_req  in  1  exception/interrupt taken
- eret_req  in  1  ERET executed
- cp0_epc  in  32  ERET target
- br1_req  in  1  slot-1 branch/jump/jr taken
- br1_tgt  in  32  slot-1 target
- br2_req  in  1  slot-2 branch/jump/jr taken
- br2_tgt  in  32  slot-2 target
- pc  out  32  fetch address, registered
- pc_valid  out  1  fetch enable
- flush  out  1  kill IF/ID contents, one-cycle pulse
- addr_err  out  1  applied target misaligned, one-cycle pulse
- pend_src  out  3  pending redirect source: 0 none, 1 exc, 2 eret, 3 br1, 4 br2
- redirect_cnt  out  32  applied-redirect count (see Configuration)

## Operation
- States: BOOT, RUN, PEND.
- Reset values:
  - pc=RESET_PC, pc_valid=0, flush=0, addr_err=0, pend_src=0, redirect_cnt=0.
  - State=BOOT; pending target cleared.
- BOOT: all requests are ignored. Next cycle: pc_valid=1, pc stays RESET_PC, go to RUN.
- Priority: exc > eret > br1 > br2. Only the winner is used; losers are dropped.
- RUN with stall=0:
  - With a request: load the winner's target (EXC_VEC, cp0_epc, br1_tgt, br2_tgt), pulse flush, stay in RUN.
  - Without a request: pc <= pc+STEP, mod 2^32 (wraps 0xFFFF_FFF8 -> 0x0000_0000).
- RUN with stall=1: pc holds.
  - With a request: capture the winner's source and target, go to PEND.
  - Without a request: stay in RUN.
- PEND, stall=1: pc holds.
  - A new request of strictly higher priority replaces the pending one, including its target.
  - A request of equal or lower priority is ignored.
- PEND, stall=0:
  - Compare a same-cycle request against the pending one; the higher priority wins.
  - Load the winning target, pulse flush, clear pending, go to RUN.
- addr_err: pulses with the load when the applied target has [1:0]!=0. pc still takes the misaligned value; CP0 reports AdEL.
- pc_valid=1 in RUN and PEND.
- pend_src reflects the pending register and is 0 in RUN.

## Timing
- Request at edge N with stall=0: pc=target and flush=1 after edge N+1; flush=0 after edge N+2.
- Request during a stall: applied on the first edge where stall is sampled 0. Zero extra bubble beyond the stall.
- Stall sampled 1: pc unchanged the next cycle; no flush.
- Reset sampled 1 in any state (including PEND with stall=1): next cycle shows the reset values; the pending redirect is lost.
- All outputs are registered; no combinational path from input to output.

## Configuration
- PC_REDIR_CNT_EN defined:
  - redirect_cnt increments by 1 on each applied redirect (each flush pulse), wraps at 2^32.
  - Cleared by reset.
- PC_REDIR_CNT_EN undefined: redirect_cnt is tied to 0 and no counter register is built.

## Test plan
- Reset then release: pc=0xBFC0_0000 with pc_valid=0 for one cycle, then pc_valid=1. Following cycles give 0xBFC0_0008, 0xBFC0_0010.
- br1_req with br1_tgt=0xBFC0_0100 at stall=0: next cycle pc=0xBFC0_0100, flush=1 for exactly one cycle, pend_src=0.
- stall=1 for 3 cycles; br2_req (tgt 0x8000_0040) in cycle 1, exc_req in cycle 2, br1_req in cycle 3:
  - pend_src goes 4 -> 1 -> 1; pc is held.
  - After stall drops: pc=0xBFC0_0380, flush pulse.
- Simultaneous exc_req and eret_req (cp0_epc=0x8000_1000) with stall=0: pc=0xBFC0_0380. Same-cycle br1_req with tgt 0x8000_0002: when applied alone, addr_err=1 and pc=0x8000_0002.
- Reset asserted while in PEND: next cycle pc=0xBFC0_0000, pend_src=0, flush=0, redirect_cnt=0.
- With PC_REDIR_CNT_EN: 5 applied redirects give redirect_cnt=5. Captured-then-replaced requests count once. Without the macro the count stays 0.
